disp7_multi_ctrl: RTL and testbench



---
 rtl/disp7_multi_ctrl_if.sv | 31 +++
 rtl/disp7_multi_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_disp7_multi_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/disp7_multi_ctrl_if.sv
// Bus bundle for disp7_multi_ctrl: load/mode/data toward the controller,
// status flags and segment drive back from it.
//
// Handshake: the source raises LOAD for one or more cycles with DIN/MODE
// stable; the controller samples them on a rising edge only while idle
// (BUSY=0 and not in the latch cycle). BUSY is high from that edge until
// the display update, and DONE pulses for exactly one cycle on the edge
// that updates HEX and OVF. LOAD seen while BUSY=1 is dropped, not queued.
interface disp7_multi_ctrl_if #(
    parameter int DIGITS = 4,
    parameter int IN_W   = 14
);
    logic [IN_W-1:0]     DIN;
    logic                LOAD;
    logic                MODE;
    logic                BUSY;
    logic                DONE;
    logic                OVF;
    logic [7*DIGITS-1:0] HEX;
    logic [1:0]          dbg_state;   // controller FSM state for checkers

    modport master (
        output DIN, LOAD, MODE,
        input  BUSY, DONE, OVF, HEX, dbg_state
    );

    modport slave (
        input  DIN, LOAD, MODE,
        output BUSY, DONE, OVF, HEX, dbg_state
    );
endinterface

// File: rtl/disp7_multi_ctrl.sv
// Multi-digit 7-segment controller for the DE2 HEX bank.
// Captures DIN on LOAD and shows it in hex (MODE=0) or decimal (MODE=1).
// Decimal uses an iterative double-dabble converter, one input bit per cycle.
// Optional build macro DISP_LZ_BLANK_EN: blank leading zero digits
// (digit 0 always shown, overflow dashes unaffected).
module disp7_multi_ctrl #(
    parameter int DIGITS = 4,
    parameter int IN_W   = 14
) (
    input logic               CLOCK_50,
    input logic               RST_N,
    disp7_multi_ctrl_if.slave bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    // Segment patterns, bit order g..a, active-low
    function automatic logic [6:0] seg_encode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    state_t              state_q, state_d;
    logic [IN_W-1:0]     shift_q, shift_d;      // captured word; shifts during CONV
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic                ovf_acc_q, ovf_acc_d;  // sticky: BCD overflowed top digit
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;

    logic [BCD_W-1:0]        bcd_adj;
    logic [31:0]             din_wide;
    logic                    hex_ovf;
    logic [DIGITS-1:0][3:0]  digit_val;
    logic [DIGITS-1:0]       blank_mask;
    logic                    latch_ovf;
    logic [7*DIGITS-1:0]     latch_hex;

    // Double-dabble correction: add 3 to every BCD nibble of 5 or more
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Display image presented at LATCH: digit values, overflow and blanking
    always_comb begin
        din_wide = '0;
        din_wide[IN_W-1:0] = shift_q;

        // In hex mode anything above the top displayed nibble is overflow
        hex_ovf = 1'b0;
        for (int b = 4 * DIGITS; b < 32; b++) begin
            if (din_wide[b]) begin
                hex_ovf = 1'b1;
            end
        end

        for (int i = 0; i < DIGITS; i++) begin
            digit_val[i] = mode_q ? bcd_q[4*i +: 4] : din_wide[4*i +: 4];
        end

        latch_ovf = mode_q ? ovf_acc_q : hex_ovf;

        blank_mask = '0;
`ifdef DISP_LZ_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (lead && (digit_val[i] == 4'd0)) begin
                    blank_mask[i] = 1'b1;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif

        latch_hex = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (latch_ovf) begin
                latch_hex[7*i +: 7] = SEG_DASH;
            end else if (blank_mask[i]) begin
                latch_hex[7*i +: 7] = SEG_BLANK;
            end else begin
                latch_hex[7*i +: 7] = seg_encode(digit_val[i]);
            end
        end
    end

    // Next-state logic for the IDLE/CONV/LATCH controller and its outputs
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        ovf_acc_d = ovf_acc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        hex_d     = hex_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.LOAD) begin
                    shift_d   = bus.DIN;
                    mode_d    = bus.MODE;
                    bcd_d     = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_W'(IN_W);
                    busy_d    = 1'b1;
                    state_d   = bus.MODE ? ST_CONV : ST_LATCH;
                end
            end
            ST_CONV: begin
                bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[IN_W-1]};
                shift_d = shift_q << 1;
                if (bcd_adj[BCD_W-1]) begin
                    ovf_acc_d = 1'b1;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                hex_d   = latch_hex;
                ovf_d   = latch_ovf;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset blanks the display and aborts conversion
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            ovf_acc_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            hex_q     <= '1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            ovf_acc_q <= ovf_acc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            hex_q     <= hex_d;
        end
    end

    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.OVF       = ovf_q;
    assign bus.HEX       = hex_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_disp7_multi_ctrl.sv
// Self-checking bench for disp7_multi_ctrl (DIGITS=4, IN_W=14).
// Expected {OVF,HEX} words and DONE edges are queued when a LOAD is driven
// and compared when DONE pulses. Build with DISP_LZ_BLANK_EN to exercise
// leading-zero blanking; the reference model follows the same macro.
module tb_disp7_multi_ctrl;

    localparam int DIGITS = 4;
    localparam int IN_W   = 14;
    localparam int HEX_W  = 7 * DIGITS;
    localparam int W      = HEX_W + 1;

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    disp7_multi_ctrl_if #(.DIGITS(DIGITS), .IN_W(IN_W)) bus ();

    disp7_multi_ctrl #(.DIGITS(DIGITS), .IN_W(IN_W)) dut (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .bus      (bus)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: {OVF, HEX} for a value/mode pair
    function automatic logic [W-1:0] model(input logic [IN_W-1:0] d, input logic m);
        logic [3:0]       dig [DIGITS];
        logic [DIGITS-1:0] blank;
        logic [HEX_W-1:0] h;
        logic             ovf;
        longint           v;
        longint           lim;
        v   = 0;
        v   = d;
        lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        if (m) begin
            ovf = (v >= lim);
            for (int i = 0; i < DIGITS; i++) begin
                dig[i] = 4'(v % 10);
                v = v / 10;
            end
        end else begin
            ovf = ((v >> (4 * DIGITS)) != 0);
            for (int i = 0; i < DIGITS; i++) dig[i] = 4'((v >> (4 * i)) & 15);
        end
        blank = '0;
`ifdef DISP_LZ_BLANK_EN
        begin
            bit lead;
            lead = 1'b1;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (lead && dig[i] == 4'd0) blank[i] = 1'b1;
                else lead = 1'b0;
            end
        end
`endif
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf)           h[7*i +: 7] = 7'b0111111;
            else if (blank[i]) h[7*i +: 7] = 7'b1111111;
            else               h[7*i +: 7] = SEG[dig[i]];
        end
        return {ovf, h};
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge; LOAD is sampled on the next rising edge (k).
    task automatic drive_load(input logic [IN_W-1:0] d, input logic m, input bit accept);
        bus.DIN  = d;
        bus.MODE = m;
        bus.LOAD = 1'b1;
        chk("busy_at_load", 64'(bus.BUSY), 64'(!accept));
        if (accept) begin
            exp_q.push_back(model(d, m));
            exp_cyc_q.push_back(cyc + 1 + (m ? IN_W + 1 : 1));
        end
        @(negedge clk);
        bus.LOAD = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor ----------------
    logic [W-1:0] mon_e;
    int           mon_c;
    logic         done_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.DONE) begin
                chk("done_one_cycle", 64'(done_prev), 64'd0);
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 64'(bus.DONE), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_c = exp_cyc_q.pop_front();
                    chk("hex", 64'(bus.HEX), 64'(mon_e[HEX_W-1:0]));
                    chk("ovf", 64'(bus.OVF), 64'(mon_e[HEX_W]));
                    chk("done_edge", 64'(cyc), 64'(mon_c));
                    chk("busy_at_done", 64'(bus.BUSY), 64'd0);
                end
            end
            done_prev = bus.DONE;
        end else begin
            done_prev = 1'b0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [W-1:0] hold_e;
        bus.DIN  = '0;
        bus.MODE = 1'b0;
        bus.LOAD = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_hex",   64'(bus.HEX),  64'({HEX_W{1'b1}}));
        chk("rst_busy",  64'(bus.BUSY), 64'd0);
        chk("rst_done",  64'(bus.DONE), 64'd0);
        chk("rst_ovf",   64'(bus.OVF),  64'd0);
        chk("rst_state", 64'(bus.dbg_state), 64'd0);

        rst_n = 1'b1;
        @(negedge clk);

        // Decimal 1234: BUSY spans 15 cycles, DONE at k+15
        drive_load(14'd1234, 1'b1, 1'b1);
        n = 0;
        while (bus.BUSY && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles_1234", 64'(n), 64'd15);
        wait_drain();
        chk("hex_1234", 64'(bus.HEX),
            64'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}));

        // Decimal overflow
        drive_load(14'd10000, 1'b1, 1'b1);
        wait_drain();
        chk("ovf_10000", 64'(bus.OVF), 64'd1);
        chk("hex_10000", 64'(bus.HEX), 64'({DIGITS{7'b0111111}}));

        // Hex 2F3A
        drive_load(14'h2F3A, 1'b0, 1'b1);
        wait_drain();
        chk("hex_2f3a", 64'(bus.HEX),
            64'({7'b0100100, 7'b0001110, 7'b0110000, 7'b0001000}));

        // 9999 with a second LOAD during conversion (ignored); display holds
        drive_load(14'd9999, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        drive_load(14'd5, 1'b1, 1'b0);
        wait_drain();
        hold_e = model(14'd9999, 1'b1);
        repeat (20) @(negedge clk);
        chk("hold_9999", 64'(bus.HEX), 64'(hold_e[HEX_W-1:0]));

        // LOAD in the LATCH cycle is dropped; LOAD right after DONE is taken
        drive_load(14'h0ABC, 1'b0, 1'b1);
        drive_load(14'h1111, 1'b0, 1'b0);
        chk("done_before_reload", 64'(bus.DONE), 64'd1);
        drive_load(14'h3FFF, 1'b0, 1'b1);
        wait_drain();

        // Small values: leading-zero behaviour depends on build
        drive_load(14'd7, 1'b1, 1'b1);
        wait_drain();
        drive_load(14'd0, 1'b1, 1'b1);
        wait_drain();
        drive_load(14'd0, 1'b0, 1'b1);
        wait_drain();

        // Random mix
        for (int i = 0; i < 10; i++) begin
            drive_load(IN_W'($urandom_range(0, (1 << IN_W) - 1)), 1'($urandom_range(0, 1)), 1'b1);
            wait_drain();
        end

        // Reset mid-conversion
        drive_load(14'd4321, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        chk("midrst_hex",   64'(bus.HEX),  64'({HEX_W{1'b1}}));
        chk("midrst_busy",  64'(bus.BUSY), 64'd0);
        chk("midrst_done",  64'(bus.DONE), 64'd0);
        chk("midrst_ovf",   64'(bus.OVF),  64'd0);
        chk("midrst_state", 64'(bus.dbg_state), 64'd0);
        exp_q.delete();
        exp_cyc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_load(14'd4321, 1'b1, 1'b1);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
